// File: rtl/alu_if.sv
// Operand/result bundle between an instruction source and the registered ALU.
// The master drives the instruction word and operands; the ALU returns result and flags.
interface alu_if;
  logic [31:0] instruction;
  logic [31:0] reg_A;
  logic [31:0] reg_B;
  logic [31:0] result;
  logic [2:0]  flags;

  modport master (
    output instruction, reg_A, reg_B,
    input  result, flags
  );

  modport slave (
    input  instruction, reg_A, reg_B,
    output result, flags
  );
endinterface

// File: rtl/alu.sv
// Single-cycle-latency MIPS-32 ALU: decodes R-type and the supported I-type opcodes.
// The result and flags are registered, and the registers are cleared asynchronously by rst_n.
module alu (
  input  logic  clk,
  input  logic  rst_n,
  alu_if.slave  bus
);
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  logic [5:0]  opcode;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [15:0] imm16;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;
  logic [31:0] sum_ab;
  logic [31:0] diff_ab;
  logic [31:0] sum_ai;
  logic        ovf_add;
  logic        ovf_sub;
  logic        ovf_addi;

  logic [31:0] result_reg;
  logic [31:0] result_next;
  logic [2:0]  flags_reg;
  logic [2:0]  flags_next;

  assign opcode = bus.instruction[31:26];
  assign shamt  = bus.instruction[10:6];
  assign funct  = bus.instruction[5:0];
  assign imm16  = bus.instruction[15:0];
  assign op_a   = bus.reg_A;
  assign op_b   = bus.reg_B;

  assign imm_sext = {{16{imm16[15]}}, imm16};
  assign imm_zext = {16'h0000, imm16};
  assign sum_ab   = op_a + op_b;
  assign diff_ab  = op_a - op_b;
  assign sum_ai   = op_a + imm_sext;

  // Overflow: operands of equal sign produce a result of the opposite sign.
  // For subtraction, the second operand is -op_b, so op_b must have the opposite sign.
  assign ovf_add  = (op_a[31] == op_b[31])    && (sum_ab[31]  != op_a[31]);
  assign ovf_sub  = (op_a[31] != op_b[31])    && (diff_ab[31] != op_a[31]);
  assign ovf_addi = (op_a[31] == imm_sext[31]) && (sum_ai[31] != op_a[31]);

  always_comb begin
    result_next = 32'h0000_0000;
    flags_next  = 3'b000;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_SLL:  result_next = op_b << shamt;
          FN_SRL:  result_next = op_b >> shamt;
          FN_SRA:  result_next = $signed(op_b) >>> shamt;
          FN_SLLV: result_next = op_b << op_a[4:0];
          FN_SRLV: result_next = op_b >> op_a[4:0];
          FN_SRAV: result_next = $signed(op_b) >>> op_a[4:0];
          FN_ADD: begin
            result_next   = sum_ab;
            flags_next[2] = ovf_add;
          end
          FN_ADDU: result_next = sum_ab;
          FN_SUB: begin
            result_next   = diff_ab;
            flags_next[2] = ovf_sub;
          end
          FN_SUBU: result_next = diff_ab;
          FN_AND:  result_next = op_a & op_b;
          FN_OR:   result_next = op_a | op_b;
          FN_XOR:  result_next = op_a ^ op_b;
          FN_NOR:  result_next = ~(op_a | op_b);
          FN_SLT: begin
            flags_next[1] = $signed(op_a) < $signed(op_b);
            result_next   = {31'd0, flags_next[1]};
          end
          FN_SLTU: begin
            flags_next[1] = op_a < op_b;
            result_next   = {31'd0, flags_next[1]};
          end
          default: ;
        endcase
      end
      OP_BEQ: begin
        result_next   = diff_ab;
        flags_next[0] = (op_a == op_b);
      end
      OP_BNE: begin
        result_next   = diff_ab;
        flags_next[0] = (op_a != op_b);
      end
      OP_ADDI: begin
        result_next   = sum_ai;
        flags_next[2] = ovf_addi;
      end
      OP_ADDIU, OP_LW, OP_SW: result_next = sum_ai;
      OP_SLTI: begin
        flags_next[1] = $signed(op_a) < $signed(imm_sext);
        result_next   = {31'd0, flags_next[1]};
      end
      OP_SLTIU: begin
        flags_next[1] = op_a < imm_sext;
        result_next   = {31'd0, flags_next[1]};
      end
      OP_ANDI: result_next = op_a & imm_zext;
      OP_ORI:  result_next = op_a | imm_zext;
      OP_XORI: result_next = op_a ^ imm_zext;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_reg <= 32'h0000_0000;
      flags_reg  <= 3'b000;
    end else begin
      result_reg <= result_next;
      flags_reg  <= flags_next;
    end
  end

  assign bus.result = result_reg;
  assign bus.flags  = flags_reg;
endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for the registered MIPS ALU, with hand-computed expectations,
// plus sequences that check register latency and asynchronous reset.
module tb_alu;
  logic clk;
  logic rst_n;
  alu_if bus ();

  alu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_result;
    logic [2:0]  exp_flags;
  } vec_t;

  vec_t vecs[$];
  int   tests;
  int   fails;

  function automatic logic [31:0] rtype(input logic [4:0] sa, input logic [5:0] fn);
    return {6'b000000, 15'd0, sa, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [15:0] imm);
    return {op, 10'd0, imm};
  endfunction

  function automatic void add_vec(input string n, input logic [31:0] ins, input logic [31:0] a,
                                  input logic [31:0] b, input logic [31:0] r, input logic [2:0] f);
    vec_t v;
    v.name = n; v.instr = ins; v.a = a; v.b = b; v.exp_result = r; v.exp_flags = f;
    vecs.push_back(v);
  endfunction

  task automatic check(input string n, input logic [31:0] er, input logic [2:0] ef);
    tests++;
    if (bus.result !== er || bus.flags !== ef) begin
      fails++;
      $display("FAIL %s: got result=%08h flags=%03b, expected result=%08h flags=%03b",
               n, bus.result, bus.flags, er, ef);
    end else begin
      $display("ok   %s: result=%08h flags=%03b", n, bus.result, bus.flags);
    end
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    bus.instruction = ins;
    bus.reg_A       = a;
    bus.reg_B       = b;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    drive(32'h0, 32'h0, 32'h0);

    add_vec("sll_2",      rtype(5'd2,  6'b000000), 32'h0,        32'h1,        32'h0000_0004, 3'b000);
    add_vec("sllv_4",     rtype(5'd0,  6'b000100), 32'h4,        32'h1,        32'h0000_0010, 3'b000);
    add_vec("sra_2",      rtype(5'd2,  6'b000011), 32'h0,        32'h8000_0021, 32'hE000_0008, 3'b000);
    add_vec("srl_2",      rtype(5'd2,  6'b000010), 32'h0,        32'h11,       32'h0000_0004, 3'b000);
    add_vec("srav_31",    rtype(5'd0,  6'b000111), 32'h1F,       32'h8000_0000, 32'hFFFF_FFFF, 3'b000);
    add_vec("srlv_31",    rtype(5'd0,  6'b000110), 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0001, 3'b000);
    add_vec("sll_0",      rtype(5'd0,  6'b000000), 32'h0,        32'hDEAD_BEEF, 32'hDEAD_BEEF, 3'b000);
    add_vec("sll_31",     rtype(5'd31, 6'b000000), 32'h0,        32'h3,        32'h8000_0000, 3'b000);
    add_vec("add_ovf1",   rtype(5'd0,  6'b100000), 32'h4,        32'h7FFF_FFFE, 32'h8000_0002, 3'b100);
    add_vec("add_ovf2",   rtype(5'd0,  6'b100000), 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 3'b100);
    add_vec("add_max1",   rtype(5'd0,  6'b100000), 32'h7FFF_FFFF, 32'h1,        32'h8000_0000, 3'b100);
    add_vec("addu_max1",  rtype(5'd0,  6'b100001), 32'h7FFF_FFFF, 32'h1,        32'h8000_0000, 3'b000);
    add_vec("sub_ovf",    rtype(5'd0,  6'b100010), 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 3'b100);
    add_vec("subu_neg",   rtype(5'd0,  6'b100011), 32'h5,        32'h7,        32'hFFFF_FFFE, 3'b000);
    add_vec("sub_neg",    rtype(5'd0,  6'b100010), 32'h5,        32'h7,        32'hFFFF_FFFE, 3'b000);
    add_vec("addu_4p1",   rtype(5'd0,  6'b100001), 32'h4,        32'h1,        32'h0000_0005, 3'b000);
    add_vec("and",        rtype(5'd0,  6'b100100), 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 3'b000);
    add_vec("or",         rtype(5'd0,  6'b100101), 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 3'b000);
    add_vec("xor",        rtype(5'd0,  6'b100110), 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 3'b000);
    add_vec("nor",        rtype(5'd0,  6'b100111), 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h000F_000F, 3'b000);
    add_vec("slt_4_8",    rtype(5'd0,  6'b101010), 32'h4,        32'h8,        32'h0000_0001, 3'b010);
    add_vec("slt_12_8",   rtype(5'd0,  6'b101010), 32'hC,        32'h8,        32'h0000_0000, 3'b000);
    add_vec("slt_m1_1",   rtype(5'd0,  6'b101010), 32'hFFFF_FFFF, 32'h1,        32'h0000_0001, 3'b010);
    add_vec("sltu_m1_1",  rtype(5'd0,  6'b101011), 32'hFFFF_FFFF, 32'h1,        32'h0000_0000, 3'b000);
    add_vec("sltiu_1_8",  itype(6'b001011, 16'h0008), 32'h1,     32'hDEAD_0000, 32'h0000_0001, 3'b010);
    add_vec("slti_m2_m1", itype(6'b001010, 16'hFFFF), 32'hFFFF_FFFE, 32'h0,     32'h0000_0001, 3'b010);
    add_vec("sltiu_sext", itype(6'b001011, 16'hFFFF), 32'h5,     32'h0,        32'h0000_0001, 3'b010);
    add_vec("beq_2_2",    itype(6'b000100, 16'h0010), 32'h2,     32'h2,        32'h0000_0000, 3'b001);
    add_vec("beq_8_2",    itype(6'b000100, 16'h0010), 32'h8,     32'h2,        32'h0000_0006, 3'b000);
    add_vec("bne_2_2",    itype(6'b000101, 16'h0010), 32'h2,     32'h2,        32'h0000_0000, 3'b000);
    add_vec("bne_0_2",    itype(6'b000101, 16'h0010), 32'h0,     32'h2,        32'hFFFF_FFFE, 3'b001);
    add_vec("addi_ovf",   itype(6'b001000, 16'hFFFF), 32'h8000_0000, 32'h0,    32'h7FFF_FFFF, 3'b100);
    add_vec("addiu_wrap", itype(6'b001001, 16'hFFFF), 32'h8000_0000, 32'h0,    32'h7FFF_FFFF, 3'b000);
    add_vec("xori",       itype(6'b001110, 16'h000A), 32'h6,     32'hFFFF_FFFF, 32'h0000_000C, 3'b000);
    add_vec("andi_zext",  itype(6'b001100, 16'h8001), 32'hFFFF_FFFF, 32'h0,    32'h0000_8001, 3'b000);
    add_vec("ori_zext",   itype(6'b001101, 16'hFFFF), 32'h1234_0000, 32'h0,    32'h1234_FFFF, 3'b000);
    add_vec("lw",         itype(6'b100011, 16'h000A), 32'hF,     32'h0,        32'h0000_0019, 3'b000);
    add_vec("sw_negoff",  itype(6'b101011, 16'hFFFC), 32'h100,   32'h0,        32'h0000_00FC, 3'b000);
    add_vec("bad_opcode", itype(6'b111111, 16'h1234), 32'h5,     32'h6,        32'h0000_0000, 3'b000);
    add_vec("bad_funct",  rtype(5'd0,  6'b001000), 32'h5,        32'h6,        32'h0000_0000, 3'b000);

    // Reset state, held across a clock edge while rst_n is low.
    #12;
    check("reset_hold", 32'h0, 3'b000);
    drive(rtype(5'd0, 6'b100001), 32'h4, 32'h1);
    @(posedge clk); #1;
    check("reset_edge", 32'h0, 3'b000);

    // The first edge after release registers a normal operation.
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("first_after_rst", 32'h0000_0005, 3'b000);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].instr, vecs[i].a, vecs[i].b);
      @(posedge clk); #1;
      check(vecs[i].name, vecs[i].exp_result, vecs[i].exp_flags);
    end

    // Outputs must not follow the inputs before the next edge.
    @(negedge clk);
    drive(rtype(5'd0, 6'b100000), 32'h7FFF_FFFF, 32'h1);
    @(posedge clk); #1;
    check("latency_load", 32'h8000_0000, 3'b100);
    @(negedge clk);
    drive(rtype(5'd0, 6'b100001), 32'h1, 32'h1);
    #2;
    check("no_comb_path", 32'h8000_0000, 3'b100);

    // Asynchronous reset mid-stream clears outputs without a clock edge.
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset", 32'h0, 3'b000);
    @(posedge clk); #1;
    check("pending_discard", 32'h0, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    drive(itype(6'b001110, 16'h000A), 32'h6, 32'h0);
    @(posedge clk); #1;
    check("resume_xori", 32'h0000_000C, 3'b000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
